// File: rtl/nukv_drop_filter.sv
// nukv_drop_filter: holds each multi-beat value in a ring buffer until its
// last beat delivers the drop verdict, then either commits it for output or
// rewinds the write pointer to discard it. Values longer than the buffer are
// dropped and the rest of the value is absorbed without storage.
module nukv_drop_filter #(
   parameter int MEMORY_WIDTH = 512,
   parameter int DEPTH        = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [MEMORY_WIDTH-1:0] input_data,
   input  logic                    input_valid,
   input  logic                    input_last,
   input  logic                    input_drop,
   output logic                    input_ready,
   output logic [MEMORY_WIDTH-1:0] output_data,
   output logic                    output_valid,
   output logic                    output_last,
   input  logic                    output_ready,
   output logic [31:0]             count_passed,
   output logic [31:0]             count_dropped,
   output logic                    error_overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   typedef enum logic {ST_FILL, ST_FLUSH} state_t;

   state_t                  state_q;
   logic [PW-1:0]           wr_ptr_q, commit_ptr_q, rd_ptr_q;
   logic [31:0]             passed_q, dropped_q;
   logic                    overflow_q;
   logic [MEMORY_WIDTH:0]   mem_q [DEPTH];
   logic [MEMORY_WIDTH-1:0] out_data_q;
   logic                    out_valid_q, out_last_q;

   logic [PW-1:0]           used, pending, wr_ptr_d;
   logic                    accept, do_write, do_read;

   // Occupancy, handshake and read/write enables
   always_comb begin
      used        = wr_ptr_q - rd_ptr_q;
      pending     = wr_ptr_q - commit_ptr_q;
      wr_ptr_d    = wr_ptr_q + PW'(1);
      input_ready = (state_q == ST_FLUSH) || (used < PW'(DEPTH));
      accept      = input_valid && input_ready;
      do_write    = accept && (state_q == ST_FILL) && !(input_last && input_drop);
      do_read     = (rd_ptr_q != commit_ptr_q) && (!out_valid_q || output_ready);
   end

   // Ring storage: only slots beyond rd_ptr are ever written, so no reset needed
   always_ff @(posedge clk) begin
      if (do_write) begin
         mem_q[wr_ptr_q[AW-1:0]] <= {input_last, input_data};
      end
   end

   // Write-side FSM: commit, rewind on drop, overflow detection and statistics
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_FILL;
         wr_ptr_q     <= '0;
         commit_ptr_q <= '0;
         passed_q     <= '0;
         dropped_q    <= '0;
         overflow_q   <= 1'b0;
      end else begin
         overflow_q <= 1'b0;
         case (state_q)
            ST_FILL: begin
               if (accept) begin
                  if (input_last && !input_drop) begin
                     wr_ptr_q     <= wr_ptr_d;
                     commit_ptr_q <= wr_ptr_d;
                     passed_q     <= passed_q + 32'd1;
                  end else if (input_last) begin
                     wr_ptr_q  <= commit_ptr_q;
                     dropped_q <= dropped_q + 32'd1;
                  end else if (pending == PW'(DEPTH - 1)) begin
                     wr_ptr_q   <= commit_ptr_q;
                     overflow_q <= 1'b1;
                     dropped_q  <= dropped_q + 32'd1;
                     state_q    <= ST_FLUSH;
                  end else begin
                     wr_ptr_q <= wr_ptr_d;
                  end
               end
            end
            ST_FLUSH: begin
               if (accept && input_last) begin
                  state_q <= ST_FILL;
               end
            end
            default: state_q <= ST_FILL;
         endcase
      end
   end

   // Output register: refill from committed entries whenever it is empty or consumed
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q    <= '0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else if (do_read) begin
         {out_last_q, out_data_q} <= mem_q[rd_ptr_q[AW-1:0]];
         out_valid_q              <= 1'b1;
         rd_ptr_q                 <= rd_ptr_q + PW'(1);
      end else if (output_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign output_data    = out_data_q;
   assign output_valid   = out_valid_q;
   assign output_last    = out_last_q;
   assign count_passed   = passed_q;
   assign count_dropped  = dropped_q;
   assign error_overflow = overflow_q;

endmodule

// File: tb/tb_nukv_drop_filter.sv
// Scoreboard bench for nukv_drop_filter: the driver pushes every beat of each
// passing value into a queue; a monitor pops and compares on each output handshake.
module tb_nukv_drop_filter;

   localparam int MW    = 512;
   localparam int DEPTH = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [MW-1:0] input_data = '0;
   logic          input_valid = 1'b0;
   logic          input_last = 1'b0;
   logic          input_drop = 1'b0;
   logic          input_ready;
   logic [MW-1:0] output_data;
   logic          output_valid;
   logic          output_last;
   logic          output_ready = 1'b1;
   logic [31:0]   count_passed;
   logic [31:0]   count_dropped;
   logic          error_overflow;

   nukv_drop_filter #(.MEMORY_WIDTH(MW), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .input_data     (input_data),
      .input_valid    (input_valid),
      .input_last     (input_last),
      .input_drop     (input_drop),
      .input_ready    (input_ready),
      .output_data    (output_data),
      .output_valid   (output_valid),
      .output_last    (output_last),
      .output_ready   (output_ready),
      .count_passed   (count_passed),
      .count_dropped  (count_dropped),
      .error_overflow (error_overflow)
   );

   always #5 clk = ~clk;

   logic [MW:0] exp_q[$];
   int total = 0;
   int bad = 0;
   int exp_passed = 0;
   int exp_dropped = 0;
   int ovf_seen = 0;
   bit mon_en = 1'b0;
   bit rand_rdy = 1'b0;

   task automatic check(input string name, input logic [MW:0] act, input logic [MW:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic logic [MW-1:0] pat(input int v, input int b);
      logic [31:0] w;
      w = 32'(v * 256 + b) ^ 32'h5A00_0000;
      return {16{w}};
   endfunction

   // Monitor: samples 1 time unit before each rising edge
   logic [MW:0] prev_beat;
   bit          stall_prev = 1'b0;
   always begin
      @(negedge clk);
      #4;
      if (mon_en && !rst) begin
         if (error_overflow) ovf_seen++;
         if (stall_prev) begin
            check("stall_valid", {{MW{1'b0}}, output_valid}, {{MW{1'b0}}, 1'b1});
            check("stall_beat", {output_last, output_data}, prev_beat);
         end
         if (output_valid && output_ready) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_beat actual=%h expected=none", {output_last, output_data});
            end else begin
               logic [MW:0] e;
               e = exp_q.pop_front();
               total--;
               check("out_beat", {output_last, output_data}, e);
            end
         end
         stall_prev = output_valid && !output_ready;
         prev_beat  = {output_last, output_data};
      end else begin
         stall_prev = 1'b0;
      end
   end

   // Random downstream backpressure when enabled
   always begin
      @(negedge clk);
      if (rand_rdy) output_ready = 1'($urandom_range(0, 1));
   end

   task automatic send_beat(input logic [MW-1:0] d, input logic l, input logic dr);
      int n;
      n = 0;
      @(negedge clk);
      input_valid = 1'b1;
      input_data  = d;
      input_last  = l;
      input_drop  = dr;
      while (!input_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) begin
         total++;
         bad++;
         $display("FAIL input_accept_timeout actual=stalled expected=accepted");
      end
      @(posedge clk);
      #1;
      input_valid = 1'b0;
   endtask

   task automatic send_value(input int v, input int len, input logic dr);
      if (!dr) begin
         for (int b = 0; b < len; b++) exp_q.push_back({(b == len - 1), pat(v, b)});
         exp_passed++;
      end else begin
         exp_dropped++;
      end
      for (int b = 0; b < len; b++) send_beat(pat(v, b), (b == len - 1), dr);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || output_valid) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (n >= 5000) begin
         bad++;
         $display("FAIL %s_drain_timeout actual=%0d expected=0 pending beats", name, exp_q.size());
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic check_counts(input string name);
      check({name, "_passed"}, (MW + 1)'(count_passed), (MW + 1)'(exp_passed));
      check({name, "_dropped"}, (MW + 1)'(count_dropped), (MW + 1)'(exp_dropped));
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_valid", (MW + 1)'(output_valid), '0);
      check("rst_beat", {output_last, output_data}, '0);
      check("rst_ovf", (MW + 1)'(error_overflow), '0);
      check_counts("rst");
      rst = 1'b0;
      #1;
      check("rst_ready", (MW + 1)'(input_ready), (MW + 1)'(1));
      mon_en = 1'b1;

      // Single-beat pass with latency check
      output_ready = 1'b1;
      exp_q.push_back({1'b1, {64{8'hA5}}});
      exp_passed++;
      send_beat({64{8'hA5}}, 1'b1, 1'b0);
      @(negedge clk); #4;
      check("lat_n1_valid", (MW + 1)'(output_valid), '0);
      @(negedge clk); #4;
      check("lat_n2_valid", (MW + 1)'(output_valid), (MW + 1)'(1));
      drain("single");
      check_counts("single");

      // Drop then pass
      send_value(1, 3, 1'b1);
      send_value(2, 2, 1'b0);
      drain("droppass");
      check_counts("droppass");

      // Backpressure until full
      output_ready = 1'b0;
      for (int v = 0; v < 8; v++) send_value(10 + v, 4, 1'b0);
      send_value(18, 1, 1'b0);
      @(negedge clk);
      check("full_ready", (MW + 1)'(input_ready), '0);
      output_ready = 1'b1;
      drain("full");
      check_counts("full");

      // Overflow: 40-beat value then 1-beat value
      ovf_seen = 0;
      exp_dropped++;
      for (int b = 0; b < 32; b++) send_beat(pat(30, b), 1'b0, 1'b0);
      @(negedge clk); #4;
      check("ovf_pulse", (MW + 1)'(error_overflow), (MW + 1)'(1));
      for (int b = 32; b < 40; b++) send_beat(pat(30, b), (b == 39), 1'b0);
      send_value(31, 1, 1'b0);
      drain("ovf");
      check("ovf_count", (MW + 1)'(ovf_seen), (MW + 1)'(1));
      check_counts("ovf");

      // Random stalls over 20 passing values
      rand_rdy = 1'b1;
      for (int v = 0; v < 20; v++) send_value(40 + v, int'($urandom_range(1, 16)), 1'b0);
      drain("stall");
      rand_rdy = 1'b0;
      @(negedge clk);
      output_ready = 1'b1;
      check_counts("stall");

      // Reset mid-value with a committed undelivered value
      output_ready = 1'b0;
      send_beat(pat(70, 0), 1'b1, 1'b0);
      send_beat(pat(71, 0), 1'b0, 1'b0);
      send_beat(pat(71, 1), 1'b0, 1'b0);
      mon_en = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      exp_q.delete();
      exp_passed = 0;
      exp_dropped = 0;
      check("mid_rst_valid", (MW + 1)'(output_valid), '0);
      check("mid_rst_beat", {output_last, output_data}, '0);
      check_counts("mid_rst");
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("mid_rst_ready", (MW + 1)'(input_ready), (MW + 1)'(1));
      mon_en = 1'b1;
      output_ready = 1'b1;
      send_value(80, 1, 1'b0);
      drain("post_rst");
      repeat (10) @(negedge clk);
      check_counts("post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
